// File: rtl/dmem_access_master.sv
// dmem_access_master: initiator side of the data-memory read/write/ready
// handshake. Latches one pipeline load/store, screens func3 and alignment,
// pulses the controller enable once, follows ready low -> high and returns a
// one-cycle response. A watchdog aborts a transaction the controller never finishes.
module dmem_access_master #(
   parameter int ADDRESS_WIDTH  = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   input  logic                     req_is_store,
   input  logic [2:0]               req_func3,
   input  logic [ADDRESS_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0]    req_wdata,
   output logic                     stall,
   output logic                     resp_valid,
   output logic [DATA_WIDTH-1:0]    resp_rdata,
   output logic [1:0]               resp_err,
   output logic                     mem_read_En,
   output logic                     mem_write_En,
   output logic [2:0]               mem_func3,
   output logic [ADDRESS_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0]    mem_data_in,
   input  logic [DATA_WIDTH-1:0]    mem_data_out,
   input  logic                     mem_ready
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_ACK,
      ST_WAIT_DONE,
      ST_RESP
   } state_t;

   localparam logic [1:0] ERR_OK        = 2'b00;
   localparam logic [1:0] ERR_MISALIGN  = 2'b01;
   localparam logic [1:0] ERR_FUNC3     = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT   = 2'b11;

   // Timer counts 0 .. TIMEOUT_CYCLES-1; one spare bit keeps the compare simple.
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

   state_t                   state_reg;
   logic                     is_store_reg;
   logic [2:0]               func3_reg;
   logic [ADDRESS_WIDTH-1:0] addr_reg;
   logic [DATA_WIDTH-1:0]    wdata_reg;
   logic [DATA_WIDTH-1:0]    rdata_reg;
   logic [1:0]               err_reg;
   logic [TW-1:0]            timer_reg;

   logic func3_ok;
   logic align_ok;
   logic timeout_hit;
   logic issue_fire;
   logic busy_state;

   // Legality of the incoming request, judged on the raw request so the
   // decision is ready on the latch cycle.
   always_comb begin
      func3_ok = 1'b0;
      align_ok = 1'b0;
      case (req_func3)
         3'b000: begin func3_ok = 1'b1;          align_ok = 1'b1;                   end
         3'b001: begin func3_ok = 1'b1;          align_ok = ~req_addr[0];           end
         3'b010: begin func3_ok = 1'b1;          align_ok = (req_addr[1:0] == 2'b00); end
         3'b100: begin func3_ok = ~req_is_store; align_ok = 1'b1;                   end
         3'b101: begin func3_ok = ~req_is_store; align_ok = ~req_addr[0];           end
         default: begin func3_ok = 1'b0;         align_ok = 1'b0;                   end
      endcase
   end

   assign timeout_hit = (timer_reg == TIMER_LAST);
   assign busy_state  = (state_reg == ST_ISSUE) || (state_reg == ST_WAIT_ACK) ||
                        (state_reg == ST_WAIT_DONE);

   // The enable goes out in the very cycle ready is seen high; it is suppressed
   // while the watchdog is aborting and in any cycle reset is asserted.
   assign issue_fire   = ~rst && (state_reg == ST_ISSUE) && mem_ready && ~timeout_hit;
   assign mem_read_En  = issue_fire & ~is_store_reg;
   assign mem_write_En = issue_fire &  is_store_reg;

   assign stall       = ~rst && (busy_state || ((state_reg == ST_IDLE) && req_valid));
   assign resp_valid  = ~rst && (state_reg == ST_RESP);
   assign resp_rdata  = rdata_reg;
   assign resp_err    = err_reg;
   assign mem_func3   = func3_reg;
   assign mem_address = addr_reg;
   assign mem_data_in = wdata_reg;

   // Transaction FSM: latch, issue, follow the ready handshake, respond.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         is_store_reg <= 1'b0;
         func3_reg    <= '0;
         addr_reg     <= '0;
         wdata_reg    <= '0;
         rdata_reg    <= '0;
         err_reg      <= ERR_OK;
         timer_reg    <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (req_valid) begin
                  is_store_reg <= req_is_store;
                  func3_reg    <= req_func3;
                  addr_reg     <= req_addr;
                  wdata_reg    <= req_wdata;
                  timer_reg    <= '0;
                  if (!func3_ok) begin
                     err_reg   <= ERR_FUNC3;
                     rdata_reg <= '0;
                     state_reg <= ST_RESP;
                  end else if (!align_ok) begin
                     err_reg   <= ERR_MISALIGN;
                     rdata_reg <= '0;
                     state_reg <= ST_RESP;
                  end else begin
                     state_reg <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               timer_reg <= timer_reg + 1'b1;
               if (timeout_hit) begin
                  err_reg   <= ERR_TIMEOUT;
                  rdata_reg <= '0;
                  state_reg <= ST_RESP;
               end else if (mem_ready) begin
                  state_reg <= ST_WAIT_ACK;
               end
            end
            ST_WAIT_ACK: begin
               timer_reg <= timer_reg + 1'b1;
               if (timeout_hit) begin
                  err_reg   <= ERR_TIMEOUT;
                  rdata_reg <= '0;
                  state_reg <= ST_RESP;
               end else if (!mem_ready) begin
                  state_reg <= ST_WAIT_DONE;
               end
            end
            ST_WAIT_DONE: begin
               timer_reg <= timer_reg + 1'b1;
               // Completion wins over a watchdog expiring in the same cycle.
               if (mem_ready) begin
                  err_reg   <= ERR_OK;
                  rdata_reg <= is_store_reg ? '0 : mem_data_out;
                  state_reg <= ST_RESP;
               end else if (timeout_hit) begin
                  err_reg   <= ERR_TIMEOUT;
                  rdata_reg <= '0;
                  state_reg <= ST_RESP;
               end
            end
            ST_RESP: begin
               state_reg <= ST_IDLE;
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_access_master.sv
// Directed bench for dmem_access_master with a small data-memory controller
// model: reads keep ready low 4 cycles, writes 1 cycle.
module tb_dmem_access_master;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic          req_is_store;
   logic [2:0]    req_func3;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          stall;
   logic          resp_valid;
   logic [DW-1:0] resp_rdata;
   logic [1:0]    resp_err;
   logic          mem_read_En;
   logic          mem_write_En;
   logic [2:0]    mem_func3;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_data_in;
   logic [DW-1:0] mem_data_out;
   logic          mem_ready;

   always #5 clk = ~clk;

   dmem_access_master #(
      .ADDRESS_WIDTH (AW),
      .DATA_WIDTH    (DW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_is_store(req_is_store),
      .req_func3   (req_func3),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .stall       (stall),
      .resp_valid  (resp_valid),
      .resp_rdata  (resp_rdata),
      .resp_err    (resp_err),
      .mem_read_En (mem_read_En),
      .mem_write_En(mem_write_En),
      .mem_func3   (mem_func3),
      .mem_address (mem_address),
      .mem_data_in (mem_data_in),
      .mem_data_out(mem_data_out),
      .mem_ready   (mem_ready)
   );

   // ---------------- controller model ----------------
   logic        hold_off;
   logic        never_drop;
   logic        poke_en;
   logic [3:0]  poke_idx;
   logic [31:0] poke_data;
   logic        ctrl_ready;
   logic        ctrl_busy;
   logic [1:0]  ctrl_cnt;
   logic [31:0] ctrl_dout;
   logic [31:0] mem_arr [0:15];

   assign mem_ready    = ctrl_ready & ~hold_off;
   assign mem_data_out = ctrl_dout;

   function automatic logic [31:0] load_val(input logic [31:0] w, input logic [1:0] off,
                                            input logic [2:0] f3);
      logic [31:0] sh;
      sh = w >> (8 * off);
      case (f3)
         3'b000:  return {{24{sh[7]}}, sh[7:0]};
         3'b001:  return {{16{sh[15]}}, sh[15:0]};
         3'b100:  return {24'h0, sh[7:0]};
         3'b101:  return {16'h0, sh[15:0]};
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [1:0] off, input logic [2:0] f3);
      logic [31:0] m;
      m = (f3 == 3'b000) ? 32'h0000_00FF : (f3 == 3'b001) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
      m = m << (8 * off);
      return (old & ~m) | ((wd << (8 * off)) & m);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         ctrl_ready <= 1'b1;
         ctrl_busy  <= 1'b0;
         ctrl_cnt   <= 2'd0;
         ctrl_dout  <= 32'h0;
      end else if (ctrl_busy) begin
         if (ctrl_cnt == 2'd0) begin
            ctrl_ready <= 1'b1;
            ctrl_busy  <= 1'b0;
         end else begin
            ctrl_cnt <= ctrl_cnt - 2'd1;
         end
      end else if (!never_drop && mem_ready && mem_read_En) begin
         ctrl_busy  <= 1'b1;
         ctrl_ready <= 1'b0;
         ctrl_cnt   <= 2'd3;
         ctrl_dout  <= load_val(mem_arr[mem_address[5:2]], mem_address[1:0], mem_func3);
      end else if (!never_drop && mem_ready && mem_write_En) begin
         ctrl_busy  <= 1'b1;
         ctrl_ready <= 1'b0;
         ctrl_cnt   <= 2'd0;
         mem_arr[mem_address[5:2]] <= store_merge(mem_arr[mem_address[5:2]], mem_data_in,
                                                  mem_address[1:0], mem_func3);
      end
      if (poke_en) mem_arr[poke_idx] <= poke_data;
   end

   // ---------------- checking ----------------
   int n_vec  = 0;
   int n_miss = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   typedef struct {
      int          resp_cyc;
      logic [31:0] rdata;
      logic [1:0]  err;
      int          rd_cnt;
      int          wr_cnt;
      int          en_cyc;
      logic [2:0]  en_f3;
      logic [31:0] en_addr;
      logic [31:0] en_wdata;
      logic        stall_ok;
      logic        both;
   } res_t;

   typedef struct {
      logic        st;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          exp_cyc;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_err;
      int          exp_rd;
      int          exp_wr;
   } vec_t;

   task automatic poke(input logic [3:0] idx, input logic [31:0] d);
      @(posedge clk); #1;
      poke_en = 1'b1; poke_idx = idx; poke_data = d;
      @(posedge clk); #1;
      poke_en = 1'b0;
   endtask

   // Issue one request in cycle 0 and trace it cycle by cycle until resp_valid.
   task automatic run_txn(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input int hold_n, output res_t r);
      r.resp_cyc = -1; r.rdata = 'x; r.err = 'x; r.rd_cnt = 0; r.wr_cnt = 0;
      r.en_cyc = -1; r.en_f3 = '0; r.en_addr = '0; r.en_wdata = '0;
      r.stall_ok = 1'b1; r.both = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b1; req_is_store = st; req_func3 = f3; req_addr = addr; req_wdata = wd;
      for (int c = 0; c < 200; c++) begin
         hold_off = (c <= hold_n);
         @(negedge clk);
         if (mem_read_En) r.rd_cnt++;
         if (mem_write_En) r.wr_cnt++;
         if (mem_read_En && mem_write_En) r.both = 1'b1;
         if ((mem_read_En || mem_write_En) && r.en_cyc < 0) begin
            r.en_cyc = c; r.en_f3 = mem_func3; r.en_addr = mem_address; r.en_wdata = mem_data_in;
         end
         if (resp_valid) begin
            r.resp_cyc = c; r.rdata = resp_rdata; r.err = resp_err;
            if (stall) r.stall_ok = 1'b0;
            break;
         end
         if (!stall) r.stall_ok = 1'b0;
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      req_valid = 1'b0; hold_off = 1'b0;
   endtask

   task automatic check_res(input string tag, input res_t r, input int exp_cyc,
                            input logic [31:0] exp_rdata, input logic [1:0] exp_err,
                            input int exp_rd, input int exp_wr);
      check({tag, ".resp_cycle"}, r.resp_cyc, exp_cyc);
      check({tag, ".rdata"}, r.rdata, exp_rdata);
      check({tag, ".err"}, {30'h0, r.err}, {30'h0, exp_err});
      check({tag, ".rd_pulses"}, r.rd_cnt, exp_rd);
      check({tag, ".wr_pulses"}, r.wr_cnt, exp_wr);
      check({tag, ".stall_shape"}, {31'h0, r.stall_ok}, 32'd1);
      check({tag, ".both_en"}, {31'h0, r.both}, 32'd0);
      $display("txn %s: resp_cycle=%0d rdata=0x%08h err=%0b rd=%0d wr=%0d en_cycle=%0d",
               tag, r.resp_cyc, r.rdata, r.err, r.rd_cnt, r.wr_cnt, r.en_cyc);
   endtask

   vec_t vecs [12];
   res_t res;
   logic saw_resp;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      //               st  f3      addr          wdata          cyc rdata          err    rd wr
      vecs[0]  = '{1'b0, 3'b010, 32'h10, 32'h0,          7, 32'hDEADBEEF, 2'b00, 1, 0};
      vecs[1]  = '{1'b1, 3'b010, 32'h20, 32'h12345678,   4, 32'h0,        2'b00, 0, 1};
      vecs[2]  = '{1'b0, 3'b010, 32'h20, 32'h0,          7, 32'h12345678, 2'b00, 1, 0};
      vecs[3]  = '{1'b0, 3'b001, 32'h21, 32'h0,          1, 32'h0,        2'b01, 0, 0};
      vecs[4]  = '{1'b0, 3'b011, 32'h10, 32'h0,          1, 32'h0,        2'b10, 0, 0};
      vecs[5]  = '{1'b1, 3'b100, 32'h03, 32'h0,          1, 32'h0,        2'b10, 0, 0};
      vecs[6]  = '{1'b0, 3'b000, 32'h11, 32'h0,          7, 32'hFFFFFFBE, 2'b00, 1, 0};
      vecs[7]  = '{1'b1, 3'b001, 32'h22, 32'h0000ABCD,   4, 32'h0,        2'b00, 0, 1};
      vecs[8]  = '{1'b0, 3'b010, 32'h20, 32'h0,          7, 32'hABCD5678, 2'b00, 1, 0};
      vecs[9]  = '{1'b0, 3'b101, 32'h12, 32'h0,          7, 32'h0000DEAD, 2'b00, 1, 0};
      vecs[10] = '{1'b1, 3'b010, 32'h22, 32'h55555555,   1, 32'h0,        2'b01, 0, 0};
      vecs[11] = '{1'b0, 3'b110, 32'h10, 32'h0,          1, 32'h0,        2'b10, 0, 0};

      rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_func3 = '0;
      req_addr = '0; req_wdata = '0; hold_off = 1'b0; never_drop = 1'b0;
      poke_en = 1'b0; poke_idx = '0; poke_data = '0; saw_resp = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst.stall", {31'h0, stall}, 32'd0);
      check("rst.resp_valid", {31'h0, resp_valid}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst.read_En", {31'h0, mem_read_En}, 32'd0);
      check("rst.write_En", {31'h0, mem_write_En}, 32'd0);
      check("rst.resp_rdata", resp_rdata, 32'h0);
      check("rst.resp_err", {30'h0, resp_err}, 32'h0);
      check("rst.mem_func3", {29'h0, mem_func3}, 32'h0);
      check("rst.mem_address", mem_address, 32'h0);
      check("rst.mem_data_in", mem_data_in, 32'h0);

      poke(4'd4, 32'hDEADBEEF);

      // Table-driven transactions
      for (int i = 0; i < 12; i++) begin
         run_txn(vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wdata, -1, res);
         check_res($sformatf("vec%0d", i), res, vecs[i].exp_cyc, vecs[i].exp_rdata,
                   vecs[i].exp_err, vecs[i].exp_rd, vecs[i].exp_wr);
         if (vecs[i].exp_rd + vecs[i].exp_wr > 0) begin
            check($sformatf("vec%0d.en_cycle", i), res.en_cyc, 32'd1);
            check($sformatf("vec%0d.en_func3", i), {29'h0, res.en_f3}, {29'h0, vecs[i].f3});
            check($sformatf("vec%0d.en_addr", i), res.en_addr, vecs[i].addr);
            if (vecs[i].st)
               check($sformatf("vec%0d.en_wdata", i), res.en_wdata, vecs[i].wdata);
         end
      end

      // Controller never drops ready: watchdog fires TO cycles after ISSUE entry (cycle 1)
      never_drop = 1'b1;
      run_txn(1'b0, 3'b010, 32'h10, 32'h0, -1, res);
      never_drop = 1'b0;
      check_res("timeout", res, 1 + TO, 32'h0, 2'b11, 1, 0);

      // Ready low for cycles 0..5: enable waits until cycle 6
      run_txn(1'b0, 3'b010, 32'h10, 32'h0, 5, res);
      check_res("hold", res, 12, 32'hDEADBEEF, 2'b00, 1, 0);
      check("hold.en_cycle", res.en_cyc, 32'd6);

      // Reset during WAIT_DONE (cycle 3 of a load)
      poke(4'd4, 32'h80FF0000);
      @(posedge clk); #1;
      req_valid = 1'b1; req_is_store = 1'b0; req_func3 = 3'b010; req_addr = 32'h10;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      check("midrst.busy_before", {31'h0, stall}, 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("midrst.during_stall", {31'h0, stall}, 32'd0);
      check("midrst.during_en", {30'h0, mem_read_En, mem_write_En}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; req_valid = 1'b0;
      @(negedge clk);
      check("midrst.after_stall", {31'h0, stall}, 32'd0);
      check("midrst.after_en", {30'h0, mem_read_En, mem_write_En}, 32'd0);
      check("midrst.after_err", {30'h0, resp_err}, 32'd0);
      check("midrst.after_rdata", resp_rdata, 32'h0);
      repeat (10) begin
         @(negedge clk);
         if (resp_valid) saw_resp = 1'b1;
      end
      check("midrst.no_resp", {31'h0, saw_resp}, 32'd0);
      $display("txn midrst: reset in WAIT_DONE, resp seen=%0b", saw_resp);

      run_txn(1'b0, 3'b100, 32'h13, 32'h0, -1, res);
      check_res("lbu_after_rst", res, 7, 32'h00000080, 2'b00, 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
